pu_msp430_adc: RTL and testbench
================================

Name: pu_msp430_adc

Overview:
- Memory-mapped SPI master peripheral that reads a 12-bit, 8-channel serial ADC (ADC128S022-style) over sclk/cs_n/mosi/miso.
- Sits on the MSP430 peripheral bus next to the SPI DAC writer and shares its decode scheme and SCLK divider semantics.
- Software selects a channel and starts a conversion (single or continuous), then polls status or takes an interrupt and reads the result.

Parameters:
- SCLK_DIV, 0: serial clock divider; Tsclk = Tmclk*(SCLK_DIV+1)*2; 4-bit range 0..15.
- BASE_ADDR, 16'h01A0: register base byte address; 8-byte window, 3-bit decode.

Ports:
- mclk  in  1  main system clock; all logic clocked on its rising edge.
- puc_rst  in  1  reset, synchronous, active-high.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral enable.
- per_we  in  2  byte write enables; any bit set means write, none means read.
- per_dout  out  16  read data; 0 when not selected.
- sclk  out  1  SPI clock, idle low, mode 0.
- cs_n  out  1  SPI chip select, active low.
- mosi  out  1  SPI command data to ADC.
- miso  in  1  SPI result data from ADC.
- irq  out  1  conversion-done interrupt; present only with the optional feature.

Behaviour:
- Interface: one clock mclk; reset puc_rst is synchronous and active-high.
- Register map, byte offsets:
  - 0 ADC_CTRL: b0 START (write-1 pulse, reads 0), b3:1 CHAN, b4 CONT, b5 IE (optional feature only, else reads 0).
  - 2 ADC_STAT: b0 BUSY (RO), b1 VALID, b2 OVF. Writing 1 clears VALID/OVF; writing 0 has no effect.
  - 4 ADC_DATA: {4'h0, result[11:0]}, RO. A read clears VALID on the same cycle.
  - 6: reserved, reads 0, writes ignored.
- Decode: reg_sel = per_en & per_addr[13:2]==BASE_ADDR[14:3]. Write = |per_we. per_dout is combinational, zero when not selected or not a read.
- Clock generation: div counter reloads SCLK_DIV at 0, otherwise decrements. sclk toggles when div==0.
  - Tick re = div==0 & ~sclk; tick fe = div==0 & sclk.
  - sclk free-runs from reset.
- pending flag: set by START write or by CONT at frame end; cleared at the fe tick that starts a frame.
- BUSY = pending | ~cs_n.
- FSM IDLE -> SHIFT -> IDLE:
  - IDLE: on fe with pending → cs_n=0, bitcnt=0, cmd={2'b00, CHAN, 11'b0} latched, mosi=cmd[15], state SHIFT.
  - SHIFT, each re: shreg={shreg[14:0], miso}, bitcnt+1.
  - SHIFT, each fe with bitcnt<16: mosi=next cmd bit MSB-first.
  - SHIFT, fe with bitcnt==16: cs_n=1, mosi=0, result=shreg[11:0]; OVF set if VALID already 1; VALID=1; state IDLE.
  - If CONT=1, pending is set at the same time, so the next frame starts one full sclk period later (cs_n high for exactly one sclk period).
- CHAN changes during a frame affect only the next frame.
- START while BUSY sets pending (no second queue); a frame is never aborted.
- Same-cycle conflicts:
  - VALID set by frame end with a simultaneous DATA read or STAT clear: set wins.
  - Read data returns the pre-update result.
- Reset values: sclk=0, cs_n=1, mosi=0, result=0, CTRL=0, VALID=OVF=0, pending=0, irq=0, div=SCLK_DIV, state IDLE. Reset mid-frame returns cs_n high on the next edge.
- Frame latency with SCLK_DIV=0: START write → cs_n low within 1..3 mclk; cs_n low duration 32 mclk.

Optional Feature:
- Macro PU_MSP430_ADC_IRQ_EN.
- With it: CTRL.IE is implemented and irq = VALID & IE, registered level.
- Without it: no irq port, IE reads 0, writes ignored.

Decomposition:
- Package pu_msp430_adc_pkg holds:
  - register offsets and DEC_WD=3;
  - CTRL/STAT bit indices;
  - FRAME_LEN=16, RES_WD=12;
  - the state enum {IDLE, SHIFT}.
- Sub-module pu_msp430_adc_sclk_gen (div counter, sclk, re/fe ticks), reusable for the DAC.

Test Plan:
- Single conversion, SCLK_DIV=0, CHAN=5, miso model returns 16'h0ABC → mosi carries 16'h2800 MSB-first; ADC_DATA=16'h0ABC; VALID=1; BUSY=0; cs_n low 32 mclk.
- Read ADC_DATA after VALID → VALID reads 0 next; OVF stays 0. Second conversion without reading → OVF=1; write STAT 16'h0006 → both 0.
- CONT=1, CHAN=2, SCLK_DIV=3 → back-to-back frames, cs_n high exactly 8 mclk between them. Clear CONT mid-frame → current frame completes, no further frame.
- START during frame → exactly one extra frame; BUSY stays 1 across the gap.
- puc_rst mid-frame at bit 7 → next cycle cs_n=1, mosi=0, VALID=0, data 0; no spurious VALID afterwards.
- With PU_MSP430_ADC_IRQ_EN, IE=1 → irq rises with VALID and falls on ADC_DATA read. Without the macro, writing 16'h0020 to CTRL → CTRL reads 0.

Source files
------------

// File: rtl/pu_msp430_adc_pkg.sv
// pu_msp430_adc_pkg: register map, bit positions and FSM states for the SPI ADC reader
package pu_msp430_adc_pkg;
    localparam int DEC_WD = 3;
    localparam logic [DEC_WD-1:0] CTRL_OFS = 3'd0;
    localparam logic [DEC_WD-1:0] STAT_OFS = 3'd2;
    localparam logic [DEC_WD-1:0] DATA_OFS = 3'd4;
    localparam int CTRL_START = 0;
    localparam int CTRL_CHAN = 1;
    localparam int CTRL_CONT = 4;
    localparam int CTRL_IE = 5;
    localparam int STAT_BUSY = 0;
    localparam int STAT_VALID = 1;
    localparam int STAT_OVF = 2;
    localparam int FRAME_LEN = 16;
    localparam int RES_WD = 12;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/pu_msp430_adc_sclk_gen.sv
// pu_msp430_adc_sclk_gen: free-running SPI clock divider with rise/fall ticks
module pu_msp430_adc_sclk_gen #(
    parameter logic [3:0] SCLK_DIV = 4'd0
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic re,
    output logic fe
);
    logic [3:0] div_q, div_d;
    logic sclk_q, sclk_d;
    always_comb begin
        div_d  = div_q == 4'd0 ? SCLK_DIV : div_q - 4'd1;
        sclk_d = div_q == 4'd0 ? ~sclk_q : sclk_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= SCLK_DIV;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end
    assign sclk = sclk_q;
    assign re   = (div_q == 4'd0) & ~sclk_q;
    assign fe   = (div_q == 4'd0) & sclk_q;
endmodule

// File: rtl/pu_msp430_adc.sv
// pu_msp430_adc: MSP430 peripheral reading a 12-bit SPI ADC; irq/IE exist only with PU_MSP430_ADC_IRQ_EN
module pu_msp430_adc
    import pu_msp430_adc_pkg::*;
#(
    parameter logic [3:0]  SCLK_DIV  = 4'd0,
    parameter logic [15:0] BASE_ADDR = 16'h01A0
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
`ifdef PU_MSP430_ADC_IRQ_EN
    ,
    output logic        irq
`endif
);
    logic re, fe;
    pu_msp430_adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
        .clk(mclk), .rst(puc_rst), .sclk(sclk), .re(re), .fe(fe)
    );

    logic reg_sel, wr, rd, wr_ctrl, wr_stat, rd_data, start_wr;
    logic [DEC_WD-1:0] ofs;
    assign reg_sel  = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
    assign ofs      = {per_addr[1:0], 1'b0};
    assign wr       = reg_sel & |per_we;
    assign rd       = reg_sel & ~|per_we;
    assign wr_ctrl  = wr & (ofs == CTRL_OFS);
    assign wr_stat  = wr & (ofs == STAT_OFS);
    assign rd_data  = rd & (ofs == DATA_OFS);
    assign start_wr = wr_ctrl & per_din[CTRL_START];

    state_t state_q, state_d;
    logic cs_n_q, cs_n_d, mosi_q, mosi_d;
    logic [4:0] bitcnt_q, bitcnt_d;
    logic [FRAME_LEN-1:0] cmd_q, cmd_d, cmd_new;
    logic [RES_WD-1:0] shreg_q, shreg_d, result_q, result_d;
    logic [2:0] chan_q, chan_d;
    logic cont_q, cont_d, valid_q, valid_d, ovf_q, ovf_d, pending_q, pending_d;
    logic start_frame, frame_end, busy, ie;

    assign start_frame = (state_q == IDLE) & fe & pending_q;
    assign frame_end   = (state_q == SHIFT) & fe & (bitcnt_q == 5'(FRAME_LEN));
    assign busy        = pending_q | ~cs_n_q;
    assign cmd_new     = {2'b00, chan_q, 11'b0};

    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        bitcnt_d  = bitcnt_q;
        cmd_d     = cmd_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        chan_d    = wr_ctrl ? per_din[CTRL_CHAN +: 3] : chan_q;
        cont_d    = wr_ctrl ? per_din[CTRL_CONT] : cont_q;
        if (start_frame) begin
            state_d  = SHIFT;
            cs_n_d   = 1'b0;
            bitcnt_d = 5'd0;
            mosi_d   = cmd_new[FRAME_LEN-1];
            cmd_d    = {cmd_new[FRAME_LEN-2:0], 1'b0};
        end else if (state_q == SHIFT && re) begin
            shreg_d  = {shreg_q[RES_WD-2:0], miso};
            bitcnt_d = bitcnt_q + 5'd1;
        end else if (frame_end) begin
            state_d  = IDLE;
            cs_n_d   = 1'b1;
            mosi_d   = 1'b0;
            result_d = shreg_q;
        end else if (state_q == SHIFT && fe) begin
            mosi_d = cmd_q[FRAME_LEN-1];
            cmd_d  = {cmd_q[FRAME_LEN-2:0], 1'b0};
        end
        // a completing frame wins over a same-cycle clear of VALID/OVF
        pending_d = start_wr | (frame_end & cont_q) | (pending_q & ~start_frame);
        valid_d   = frame_end | (valid_q & ~rd_data & ~(wr_stat & per_din[STAT_VALID]));
        ovf_d     = (frame_end & valid_q) | (ovf_q & ~(wr_stat & per_din[STAT_OVF]));
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            bitcnt_q  <= 5'd0;
            cmd_q     <= '0;
            shreg_q   <= '0;
            result_q  <= '0;
            chan_q    <= 3'd0;
            cont_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            bitcnt_q  <= bitcnt_d;
            cmd_q     <= cmd_d;
            shreg_q   <= shreg_d;
            result_q  <= result_d;
            chan_q    <= chan_d;
            cont_q    <= cont_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
        end
    end

`ifdef PU_MSP430_ADC_IRQ_EN
    logic ie_q, ie_d, irq_q, irq_d;
    always_comb begin
        ie_d  = wr_ctrl ? per_din[CTRL_IE] : ie_q;
        irq_d = valid_d & ie_d;
    end
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
    assign ie  = ie_q;
    assign irq = irq_q;
`else
    assign ie = 1'b0;
`endif

    assign per_dout = ~rd                ? 16'h0000 :
                      ofs == CTRL_OFS    ? {10'b0, ie, cont_q, chan_q, 1'b0} :
                      ofs == STAT_OFS    ? {13'b0, ovf_q, valid_q, busy} :
                      ofs == DATA_OFS    ? {4'h0, result_q} : 16'h0000;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;

    logic unused;
    assign unused = &{1'b0, per_din[15:5]};
endmodule

// File: tb/tb_pu_msp430_adc.sv
// tb_pu_msp430_adc: randomized bench with an ADC slave model for two divider settings
module tb_pu_msp430_adc;
    localparam logic [15:0] BASE0 = 16'h01A0;
    localparam logic [15:0] BASE3 = 16'h01B0;
    localparam logic [2:0] CTRL = 3'd0, STAT = 3'd2, DATA = 3'd4, RSVD = 3'd6;

    logic clk = 1'b0, rst = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic per_en = 1'b0;
    logic [1:0] per_we = 2'b00;
    logic [15:0] dout0, dout3;
    logic [1:0] sclk, cs_n, mosi;
    logic [1:0] miso = 2'b00;
`ifdef PU_MSP430_ADC_IRQ_EN
    logic irq0, irq3;
`endif

    always #5 clk = ~clk;

    pu_msp430_adc #(.SCLK_DIV(4'd0), .BASE_ADDR(BASE0)) u0 (
        .mclk(clk), .puc_rst(rst), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
        .per_we(per_we), .per_dout(dout0), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
        .miso(miso[0])
`ifdef PU_MSP430_ADC_IRQ_EN
        , .irq(irq0)
`endif
    );
    pu_msp430_adc #(.SCLK_DIV(4'd3), .BASE_ADDR(BASE3)) u3 (
        .mclk(clk), .puc_rst(rst), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
        .per_we(per_we), .per_dout(dout3), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
        .miso(miso[1])
`ifdef PU_MSP430_ADC_IRQ_EN
        , .irq(irq3)
`endif
    );

    int checks = 0, fails = 0, cyc = 0, wr_cyc = 0;
    int idx[2], len[2], gap[2], rises[2], started[2], done[2], fall_cyc[2], last_len[2], last_gap[2];
    logic [15:0] word[2], cap[2], last_cmd[2];
    logic [1:0] prev_cs = 2'b11, prev_sclk = 2'b00;
    bit force_en = 1'b0;
    logic [15:0] force_word = '0;

    initial for (int i = 0; i < 2; i++) begin
        idx[i] = 0; len[i] = 0; gap[i] = 0; rises[i] = 0; started[i] = 0; done[i] = 0;
        fall_cyc[i] = 0; last_len[i] = 0; last_gap[i] = 0; word[i] = '0; cap[i] = '0; last_cmd[i] = '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ADC slave: serves one word per frame MSB-first, advancing after each sclk fall
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && cs_n[i] === 1'b0) begin
                idx[i] = 0; rises[i] = 0; cap[i] = '0; len[i] = 1;
                last_gap[i] = gap[i]; fall_cyc[i] = cyc; started[i]++;
                word[i] = force_en ? force_word : 16'($urandom);
            end else if (cs_n[i] === 1'b0) begin
                len[i]++;
                if (prev_sclk[i] && !sclk[i]) idx[i]++;
                if (!prev_sclk[i] && sclk[i]) begin
                    cap[i] = {cap[i][14:0], mosi[i]};
                    rises[i]++;
                end
            end else if (!prev_cs[i]) begin
                done[i]++; last_cmd[i] = cap[i]; last_len[i] = len[i]; gap[i] = 1;
            end else gap[i]++;
            prev_cs[i] = cs_n[i] !== 1'b0;
            prev_sclk[i] = sclk[i] === 1'b1;
            miso[i] = (cs_n[i] === 1'b0 && idx[i] < 16) ? word[i][15 - idx[i]] : 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_bus(input int u, input logic [2:0] ofs);
        per_addr = (u == 0 ? BASE0[14:1] : BASE3[14:1]) | 14'(ofs >> 1);
        per_en = 1'b1;
    endtask

    task automatic bus_write(input int u, input logic [2:0] ofs, input logic [15:0] d);
        set_bus(u, ofs);
        per_we = 2'b11;
        per_din = d;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic bus_read(input int u, input logic [2:0] ofs, output logic [15:0] d);
        set_bus(u, ofs);
        per_we = 2'b00;
        #1;
        d = u == 0 ? dout0 : dout3;
        @(posedge clk);
        #1;
        per_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        force_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int u, input int n, input int budget, input string name);
        int k = 0;
        while (done[u] < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (done[u] < n) begin
            fails++;
            $display("FAIL %s: frames done %0d, required %0d", name, done[u], n);
        end
    endtask

    task automatic wait_cs_low(input int u, input string name);
        int k = 0;
        while (cs_n[u] !== 1'b0 && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (cs_n[u] !== 1'b0) begin
            fails++;
            $display("FAIL %s: cs_n %b, required 0", name, cs_n[u]);
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sclk[0], cs_n[0], mosi[0]} !== 3'b010) begin
            fails++;
            $display("FAIL reset_pins: sclk/cs_n/mosi %b, required 010", {sclk[0], cs_n[0], mosi[0]});
        end
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus_read(0, 3'(2 * r), d);
            checks++;
            if (d !== 16'h0000) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h, required 0000", 2 * r, d);
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] d;
        int n, s;
        reset_dut();
        force_en = 1'b1;
        force_word = 16'h0ABC;
        n = done[0];
        bus_write(0, CTRL, 16'h000B);
        s = wr_cyc;
        wait_done(0, n + 1, 200, "single_done");
        checks++;
        if (last_cmd[0] !== 16'h2800) begin
            fails++;
            $display("FAIL single_mosi: got %h, required 2800", last_cmd[0]);
        end
        checks++;
        if (fall_cyc[0] - s < 1 || fall_cyc[0] - s > 3) begin
            fails++;
            $display("FAIL single_latency: got %0d, required 1..3", fall_cyc[0] - s);
        end
        checks++;
        if (last_len[0] != 32) begin
            fails++;
            $display("FAIL single_cs_len: got %0d, required 32", last_len[0]);
        end
        bus_read(0, STAT, d);
        checks++;
        if (d !== 16'h0002) begin
            fails++;
            $display("FAIL single_stat: got %h, required 0002", d);
        end
        bus_read(0, DATA, d);
        checks++;
        if (d !== 16'h0ABC) begin
            fails++;
            $display("FAIL single_data: got %h, required 0abc", d);
        end
        bus_read(0, STAT, d);
        checks++;
        if (d !== 16'h0000) begin
            fails++;
            $display("FAIL single_read_clears: got %h, required 0000", d);
        end
        force_en = 1'b0;
    endtask

    task automatic test_random_ovf();
        logic [15:0] d, exp;
        logic [2:0] chan;
        for (int t = 0; t < 4; t++) begin
            chan = 3'($urandom_range(0, 7));
            bus_write(0, CTRL, 16'({chan, 1'b1}));
            wait_done(0, done[0] + 1, 200, "rand_done");
            exp = {2'b00, chan, 11'b0};
            checks++;
            if (last_cmd[0] !== exp) begin
                fails++;
                $display("FAIL rand_mosi: got %h, required %h", last_cmd[0], exp);
            end
        end
        bus_read(0, STAT, d);
        checks++;
        if (d !== 16'h0006) begin
            fails++;
            $display("FAIL ovf_stat: got %h, required 0006", d);
        end
        bus_write(0, STAT, 16'h0000);
        bus_read(0, STAT, d);
        checks++;
        if (d !== 16'h0006) begin
            fails++;
            $display("FAIL stat_write0: got %h, required 0006", d);
        end
        exp = {4'h0, word[0][11:0]};
        bus_read(0, DATA, d);
        checks++;
        if (d !== exp) begin
            fails++;
            $display("FAIL rand_data: got %h, required %h", d, exp);
        end
        bus_write(0, STAT, 16'h0006);
        bus_read(0, STAT, d);
        checks++;
        if (d !== 16'h0000) begin
            fails++;
            $display("FAIL stat_clear: got %h, required 0000", d);
        end
    endtask

    task automatic test_cont();
        logic [15:0] d, exp;
        int n, m;
        reset_dut();
        n = done[1];
        bus_write(1, CTRL, 16'h0015);
        wait_done(1, n + 2, 800, "cont_done");
        exp = {4'h0, word[1][11:0]};
        checks++;
        if (last_gap[1] != 8) begin
            fails++;
            $display("FAIL cont_gap: got %0d, required 8", last_gap[1]);
        end
        checks++;
        if (last_cmd[1] !== 16'h1000) begin
            fails++;
            $display("FAIL cont_mosi: got %h, required 1000", last_cmd[1]);
        end
        bus_read(1, DATA, d);
        checks++;
        if (d !== exp) begin
            fails++;
            $display("FAIL cont_data: got %h, required %h", d, exp);
        end
        wait_cs_low(1, "cont_third");
        bus_write(1, CTRL, 16'h0004);
        m = started[1];
        wait_done(1, m, 400, "cont_last");
        repeat (300) step();
        checks++;
        if (started[1] != m) begin
            fails++;
            $display("FAIL cont_stop: frames %0d, required %0d", started[1], m);
        end
        bus_read(1, STAT, d);
        checks++;
        if (d !== 16'h0006) begin
            fails++;
            $display("FAIL cont_stat: got %h, required 0006", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [2:0] chan;
        int n;
        reset_dut();
        n = started[1];
        chan = 3'($urandom_range(0, 7));
        bus_write(1, CTRL, 16'({chan, 1'b1}));
        wait_cs_low(1, "b2b_first");
        repeat ($urandom_range(2, 60)) step();
        bus_write(1, CTRL, 16'({chan, 1'b1}));
        wait_done(1, done[1] + 1, 400, "b2b_done1");
        bus_read(1, STAT, d);
        checks++;
        if (d !== 16'h0003) begin
            fails++;
            $display("FAIL b2b_gap_busy: got %h, required 0003", d);
        end
        wait_done(1, done[1] + 1, 400, "b2b_done2");
        repeat (300) step();
        checks++;
        if (started[1] != n + 2) begin
            fails++;
            $display("FAIL b2b_frames: got %0d, required %0d", started[1] - n, 2);
        end
        bus_read(1, STAT, d);
        checks++;
        if (d !== 16'h0006) begin
            fails++;
            $display("FAIL b2b_stat: got %h, required 0006", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        int n, k;
        reset_dut();
        force_en = 1'b1;
        force_word = 16'h0555;
        bus_write(0, CTRL, 16'h0007);
        wait_done(0, done[0] + 1, 200, "mid_first");
        force_en = 1'b0;
        n = started[0];
        bus_write(0, CTRL, 16'h0007);
        k = 0;
        while (!(started[0] == n + 1 && rises[0] == 7) && k < 200) begin
            step();
            k++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cs_n[0], mosi[0]} !== 2'b10) begin
            fails++;
            $display("FAIL mid_reset_pins: cs_n/mosi %b, required 10", {cs_n[0], mosi[0]});
        end
        rst = 1'b0;
        bus_read(0, DATA, d);
        checks++;
        if (d !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_data: got %h, required 0000", d);
        end
        repeat (100) step();
        bus_read(0, STAT, d);
        checks++;
        if (d !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_stat: got %h, required 0000", d);
        end
    endtask

    task automatic test_ie();
        logic [15:0] d;
        reset_dut();
        bus_write(0, CTRL, 16'h0026);
        bus_read(0, CTRL, d);
`ifdef PU_MSP430_ADC_IRQ_EN
        checks++;
        if (d !== 16'h0026) begin
            fails++;
            $display("FAIL ie_ctrl: got %h, required 0026", d);
        end
        bus_write(0, CTRL, 16'h0027);
        wait_done(0, done[0] + 1, 200, "ie_done");
        checks++;
        if (irq0 !== 1'b1) begin
            fails++;
            $display("FAIL irq_rise: got %b, required 1", irq0);
        end
        bus_read(0, DATA, d);
        checks++;
        if (irq0 !== 1'b0) begin
            fails++;
            $display("FAIL irq_fall: got %b, required 0", irq0);
        end
`else
        checks++;
        if (d !== 16'h0006) begin
            fails++;
            $display("FAIL ie_absent: got %h, required 0006", d);
        end
`endif
        bus_write(0, RSVD, 16'hFFFF);
        bus_read(0, RSVD, d);
        checks++;
        if (d !== 16'h0000) begin
            fails++;
            $display("FAIL reserved: got %h, required 0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random_ovf();
        test_cont();
        test_back_to_back();
        test_reset_mid();
        test_ie();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
